// File: rtl/ras_pkg.sv
// Shared types and constants for the return-address-stack controller.
package ras_pkg;

  typedef enum logic [1:0] {
    NONE,
    PUSH,
    POP,
    POPPUSH
  } ras_op_e;

  typedef enum logic [1:0] {
    IDLE,
    COPUSH,
    RECOVER
  } ras_state_e;

  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

  // x1 and x5 are the two registers that mark calls and returns.
  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_X1) || (r == LINK_X5);
  endfunction

endpackage

// File: rtl/ras_hint_decode.sv
// Classifies a JAL/JALR into a RAS operation from its rd/rs1 link-register hints.
module ras_hint_decode
  import ras_pkg::*;
(
  input  logic       is_jal,
  input  logic       is_jalr,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  output ras_op_e    op
);

  logic rd_link;
  logic rs1_link;

  assign rd_link  = is_link(rd);
  assign rs1_link = is_link(rs1);

  // Hint table; JAL takes precedence if both predecode bits are set.
  always_comb begin
    op = NONE;
    if (is_jal) begin
      op = rd_link ? PUSH : NONE;
    end else if (is_jalr) begin
      if (!rd_link && rs1_link) begin
        op = POP;
      end else if (rd_link && !rs1_link) begin
        op = PUSH;
      end else if (rd_link && rs1_link) begin
        // Same link register on both sides is a plain call, not a coroutine swap.
        op = (rd != rs1) ? POPPUSH : PUSH;
      end
    end
  end

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack controller for fetch stage 1: drives push/pop on the RAS,
// returns predicted return targets, and unwinds speculative pushes on flush.
// Optional feature macro: RAS_CTRL_COROUTINE_EN (two-cycle pop-then-push for
// coroutine jumps); when undefined a coroutine jump is handled as a plain push.
module ras_ctrl
  import ras_pkg::*;
#(
  parameter int unsigned ras_depth = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [63:0] fetch_pc,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  output logic        stall,
  output logic        pred_valid,
  output logic [63:0] pred_target,
  input  logic        commit_push,
  input  logic        commit_pop,
  input  logic        flush,
  output logic        ras_push,
  output logic        ras_pop,
  output logic [63:0] ras_idata,
  input  logic [63:0] ras_odata,
  input  logic        ras_valid,
  input  logic        ras_empty,
  input  logic        ras_full
);

  localparam int unsigned DepthW = $clog2(ras_depth + 1);
  localparam logic [DepthW-1:0] MaxDepth = DepthW'(ras_depth);
  localparam logic [DepthW-1:0] One = DepthW'(1);

  ras_state_e        state_q, state_d;
  logic [DepthW-1:0] spec_depth_q, spec_depth_d;
  logic [DepthW-1:0] commit_depth_q, commit_depth_d;
`ifdef RAS_CTRL_COROUTINE_EN
  logic [63:0]       copush_data_q, copush_data_d;
`endif

  ras_op_e           op;
  logic [63:0]       link_addr;
  logic [DepthW-1:0] spec_inc;
  logic [DepthW-1:0] spec_dec;

  ras_hint_decode u_hint_decode (
    .is_jal  (is_jal),
    .is_jalr (is_jalr),
    .rd      (rd),
    .rs1     (rs1),
    .op      (op)
  );

  assign link_addr = fetch_pc + 64'd4;
  // A push into a full RAS is lost, so the depth pins at the top.
  assign spec_inc  = (ras_full || spec_depth_q == MaxDepth) ? MaxDepth : spec_depth_q + One;
  assign spec_dec  = (spec_depth_q == '0) ? '0 : spec_depth_q - One;

  // Committed depth tracks retirement; a coroutine commit (both bits) is net zero.
  always_comb begin
    commit_depth_d = commit_depth_q;
    if (commit_push && !commit_pop && commit_depth_q != MaxDepth) begin
      commit_depth_d = commit_depth_q + One;
    end else if (commit_pop && !commit_push && commit_depth_q != '0) begin
      commit_depth_d = commit_depth_q - One;
    end
  end

  // Next-state, speculative depth and RAS command/prediction outputs.
  always_comb begin
    state_d      = state_q;
    spec_depth_d = spec_depth_q;
`ifdef RAS_CTRL_COROUTINE_EN
    copush_data_d = copush_data_q;
`endif
    stall       = 1'b0;
    pred_valid  = 1'b0;
    pred_target = '0;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    ras_idata   = '0;

    if (flush) begin
      // Flush drops any fetch op or pending coroutine push this cycle.
      if (spec_depth_q > commit_depth_q) begin
        state_d = RECOVER;
      end else begin
        state_d      = IDLE;
        spec_depth_d = commit_depth_q;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fetch_valid) begin
            unique case (op)
              PUSH: begin
                ras_push     = 1'b1;
                ras_idata    = link_addr;
                spec_depth_d = spec_inc;
              end
              POP: begin
                ras_pop      = 1'b1;
                pred_valid   = ras_valid && !ras_empty;
                pred_target  = ras_odata;
                spec_depth_d = spec_dec;
              end
`ifdef RAS_CTRL_COROUTINE_EN
              POPPUSH: begin
                ras_pop       = 1'b1;
                pred_valid    = ras_valid && !ras_empty;
                pred_target   = ras_odata;
                spec_depth_d  = spec_dec;
                copush_data_d = link_addr;
                stall         = 1'b1;
                state_d       = COPUSH;
              end
`else
              POPPUSH: begin
                ras_push     = 1'b1;
                ras_idata    = link_addr;
                spec_depth_d = spec_inc;
              end
`endif
              default: ;
            endcase
          end
        end
`ifdef RAS_CTRL_COROUTINE_EN
        COPUSH: begin
          ras_push     = 1'b1;
          ras_idata    = copush_data_q;
          spec_depth_d = spec_inc;
          state_d      = IDLE;
        end
`endif
        RECOVER: begin
          stall = 1'b1;
          if (spec_depth_q > commit_depth_q) begin
            ras_pop      = 1'b1;
            spec_depth_d = spec_dec;
            if (spec_dec <= commit_depth_q) begin
              state_d = IDLE;
            end
          end else begin
            // Commits caught up mid-unwind; realign and stop.
            state_d      = IDLE;
            spec_depth_d = commit_depth_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and depth registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      spec_depth_q   <= '0;
      commit_depth_q <= '0;
`ifdef RAS_CTRL_COROUTINE_EN
      copush_data_q  <= '0;
`endif
    end else begin
      state_q        <= state_d;
      spec_depth_q   <= spec_depth_d;
      commit_depth_q <= commit_depth_d;
`ifdef RAS_CTRL_COROUTINE_EN
      copush_data_q  <= copush_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl: an attached 8-entry RAS, directed scenarios, then random
// traffic checked every cycle against a behavioural model.
module tb_ras_ctrl;

  localparam int D = 8;

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic [63:0] fetch_pc;
  logic        is_jal;
  logic        is_jalr;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic        stall;
  logic        pred_valid;
  logic [63:0] pred_target;
  logic        commit_push;
  logic        commit_pop;
  logic        flush;
  logic        ras_push;
  logic        ras_pop;
  logic [63:0] ras_idata;
  logic [63:0] ras_odata;
  logic        ras_valid;
  logic        ras_empty;
  logic        ras_full;

  int n_total = 0;
  int n_pass  = 0;

  // Attached RAS (environment), driven by the DUT's actual commands.
  logic [63:0] env_q[$];

  // Behavioural model.
  logic [63:0] m_stk[$];
  int          m_spec;
  int          m_commit;
  int          m_mode;  // 0 normal, 1 coroutine push pending, 2 unwinding
  logic [63:0] m_pend;

  // Last sampled DUT outputs.
  logic        obs_stall, obs_pv, obs_push, obs_pop;
  logic [63:0] obs_pt, obs_idata;

  int n_st;
  int n_pp;

  ras_ctrl #(
    .ras_depth (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .is_jal      (is_jal),
    .is_jalr     (is_jalr),
    .rd          (rd),
    .rs1         (rs1),
    .stall       (stall),
    .pred_valid  (pred_valid),
    .pred_target (pred_target),
    .commit_push (commit_push),
    .commit_pop  (commit_pop),
    .flush       (flush),
    .ras_push    (ras_push),
    .ras_pop     (ras_pop),
    .ras_idata   (ras_idata),
    .ras_odata   (ras_odata),
    .ras_valid   (ras_valid),
    .ras_empty   (ras_empty),
    .ras_full    (ras_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic env_refresh();
    ras_empty = (env_q.size() == 0);
    ras_full  = (env_q.size() == D);
    ras_valid = !ras_empty;
    ras_odata = ras_empty ? 64'd0 : env_q[env_q.size()-1];
  endtask

  // 0 none, 1 push, 2 pop, 3 pop-then-push
  function automatic int hint(input logic j, input logic jr, input logic [4:0] d,
                              input logic [4:0] s);
    bit dl;
    bit sl;
    dl = (d == 5'd1) || (d == 5'd5);
    sl = (s == 5'd1) || (s == 5'd5);
    if (j) return dl ? 1 : 0;
    if (!jr) return 0;
    if (!dl && sl) return 2;
    if (dl && !sl) return 1;
    if (dl && sl) return (d != s) ? 3 : 1;
    return 0;
  endfunction

  task automatic set_idle();
    fetch_valid = 1'b0;
    fetch_pc    = '0;
    is_jal      = 1'b0;
    is_jalr     = 1'b0;
    rd          = '0;
    rs1         = '0;
    commit_push = 1'b0;
    commit_pop  = 1'b0;
    flush       = 1'b0;
  endtask

  // One clock cycle: drive, predict, compare, then let the RAS take the command.
  task automatic cyc(input logic fv, input logic [63:0] pc, input logic j, input logic jr,
                     input logic [4:0] d, input logic [4:0] s, input logic cp,
                     input logic cq, input logic fl);
    logic        e_stall, e_pv, e_push, e_pop;
    logic [63:0] e_pt, e_id;
    logic        a_push, a_pop;
    logic [63:0] a_id;
    int          op;
    @(negedge clk);
    fetch_valid = fv;
    fetch_pc    = pc;
    is_jal      = j;
    is_jalr     = jr;
    rd          = d;
    rs1         = s;
    commit_push = cp;
    commit_pop  = cq;
    flush       = fl;
    #1;
    e_stall = 0; e_pv = 0; e_push = 0; e_pop = 0; e_pt = 0; e_id = 0;
    if (fl) begin
      if (m_spec > m_commit) m_mode = 2;
      else begin
        m_mode = 0;
        m_spec = m_commit;
      end
    end else if (m_mode == 1) begin
      e_push = 1; e_id = m_pend;
      m_spec = (m_spec < D) ? m_spec + 1 : D;
      m_mode = 0;
    end else if (m_mode == 2) begin
      e_stall = 1;
      if (m_spec > m_commit) begin
        e_pop = 1;
        m_spec--;
      end
      if (m_spec <= m_commit) begin
        m_mode = 0;
        if (m_spec < m_commit) m_spec = m_commit;
      end
    end else if (fv) begin
      op = hint(j, jr, d, s);
`ifndef RAS_CTRL_COROUTINE_EN
      if (op == 3) op = 1;
`endif
      if (op == 1) begin
        e_push = 1; e_id = pc + 64'd4;
        m_spec = (m_spec < D) ? m_spec + 1 : D;
      end else if (op >= 2) begin
        e_pop = 1;
        e_pv  = (m_stk.size() > 0);
        e_pt  = e_pv ? m_stk[m_stk.size()-1] : 64'd0;
        m_spec = (m_spec > 0) ? m_spec - 1 : 0;
        if (op == 3) begin
          e_stall = 1;
          m_pend  = pc + 64'd4;
          m_mode  = 1;
        end
      end
    end
    if (cp && !cq && m_commit < D) m_commit++;
    if (cq && !cp && m_commit > 0) m_commit--;
    if (e_pop && m_stk.size() > 0) void'(m_stk.pop_back());
    if (e_push && m_stk.size() < D) m_stk.push_back(e_id);

    obs_stall = stall; obs_pv = pred_valid; obs_pt = pred_target;
    obs_push = ras_push; obs_pop = ras_pop; obs_idata = ras_idata;
    chk("stall", {63'd0, stall}, {63'd0, e_stall});
    chk("pred_valid", {63'd0, pred_valid}, {63'd0, e_pv});
    chk("pred_target", pred_target, e_pt);
    chk("ras_push", {63'd0, ras_push}, {63'd0, e_push});
    chk("ras_pop", {63'd0, ras_pop}, {63'd0, e_pop});
    chk("ras_idata", ras_idata, e_id);
    chk("push_pop_exclusive", {63'd0, ras_push & ras_pop}, 64'd0);

    a_push = ras_push; a_pop = ras_pop; a_id = ras_idata;
    @(posedge clk);
    if (a_pop && env_q.size() > 0) void'(env_q.pop_back());
    if (a_push && env_q.size() < D) env_q.push_back(a_id);
    env_refresh();
  endtask

  task automatic idle();
    cyc(1'b0, 64'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic call(input logic [63:0] pc);
    cyc(1'b1, pc, 1'b1, 1'b0, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ret(input logic [63:0] pc);
    cyc(1'b1, pc, 1'b0, 1'b1, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    @(negedge clk);
    #2;
    set_idle();
    rst = 1'b0;
    #1;
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_pred_valid", {63'd0, pred_valid}, 64'd0);
    chk("rst_pred_target", pred_target, 64'd0);
    chk("rst_ras_push", {63'd0, ras_push}, 64'd0);
    chk("rst_ras_pop", {63'd0, ras_pop}, 64'd0);
    chk("rst_ras_idata", ras_idata, 64'd0);
    env_q.delete();
    m_stk.delete();
    m_spec = 0; m_commit = 0; m_mode = 0; m_pend = '0;
    env_refresh();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [4:0] rreg();
    case ($urandom % 4)
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd5;
      default: return 5'($urandom % 32);
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    set_idle();
    env_refresh();
    do_reset();

    // Call then return.
    call(64'h1000);
    chk("call_push", {63'd0, obs_push}, 64'd1);
    chk("call_idata", obs_idata, 64'h1004);
    ret(64'h1010);
    chk("ret_valid", {63'd0, obs_pv}, 64'd1);
    chk("ret_target", obs_pt, 64'h1004);
    cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("wrap_idata", obs_idata, 64'd0);

    // Coroutine jump.
    do_reset();
    call(64'h2000);
`ifdef RAS_CTRL_COROUTINE_EN
    cyc(1'b1, 64'h3000, 1'b0, 1'b1, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
    chk("co0_target", obs_pt, 64'h2004);
    chk("co0_stall", {63'd0, obs_stall}, 64'd1);
    cyc(1'b1, 64'h3000, 1'b0, 1'b1, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
    chk("co1_push", {63'd0, obs_push}, 64'd1);
    chk("co1_idata", obs_idata, 64'h3004);
    chk("co1_stall", {63'd0, obs_stall}, 64'd0);
    ret(64'h3100);
    chk("co_ret_target", obs_pt, 64'h3004);
`else
    cyc(1'b1, 64'h3000, 1'b0, 1'b1, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0);
    chk("nco_push", {63'd0, obs_push}, 64'd1);
    chk("nco_idata", obs_idata, 64'h3004);
    chk("nco_stall", {63'd0, obs_stall}, 64'd0);
    chk("nco_pred_valid", {63'd0, obs_pv}, 64'd0);
`endif

    // Overflow: nine calls, the last one is lost.
    do_reset();
    for (int i = 1; i <= 9; i++) call(64'(i * 256));
    for (int i = 8; i >= 1; i--) begin
      ret(64'h8000);
      chk("ovf_valid", {63'd0, obs_pv}, 64'd1);
      chk("ovf_target", obs_pt, 64'(i * 256 + 4));
    end
    ret(64'h8000);
    chk("ovf_empty_valid", {63'd0, obs_pv}, 64'd0);

    // Recovery: one committed entry, three speculative ones, then flush.
    do_reset();
    cyc(1'b1, 64'hA000, 1'b1, 1'b0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
    call(64'hB000);
    call(64'hC000);
    call(64'hD000);
    cyc(1'b0, 64'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    n_st = 0;
    n_pp = 0;
    for (int i = 0; i < 5; i++) begin
      idle();
      n_st += int'(obs_stall);
      n_pp += int'(obs_pop);
    end
    chk("rec_stall_cycles", 64'(n_st), 64'd3);
    chk("rec_pops", 64'(n_pp), 64'd3);
    ret(64'hE000);
    chk("rec_ret_target", obs_pt, 64'hA004);

`ifdef RAS_CTRL_COROUTINE_EN
    // Flush during the coroutine push drops it.
    call(64'h4000);
    cyc(1'b1, 64'h4100, 1'b0, 1'b1, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h4100, 1'b0, 1'b1, 5'd1, 5'd5, 1'b0, 1'b0, 1'b1);
    chk("coflush_push", {63'd0, obs_push}, 64'd0);
    for (int i = 0; i < 3; i++) idle();
`endif

    // Reset in the middle of an unwind.
    do_reset();
    call(64'h600);
    call(64'h700);
    call(64'h800);
    cyc(1'b0, 64'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("mid_rec_pop", {63'd0, obs_pop}, 64'd1);
    do_reset();
    call(64'h5000);
    chk("post_rst_push", {63'd0, obs_push}, 64'd1);
    chk("post_rst_stall", {63'd0, obs_stall}, 64'd0);
    chk("post_rst_idata", obs_idata, 64'h5004);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      logic        fv, j, jr;
      logic [63:0] pc;
      int          kind;
      fv   = ($urandom % 4) != 0;
      pc   = {$urandom(), $urandom()} & ~64'd3;
      kind = int'($urandom % 4);
      j    = (kind == 0);
      jr   = (kind == 1) || (kind == 3);
      cyc(fv, pc, j, jr, rreg(), rreg(), ($urandom % 6) == 0, ($urandom % 6) == 0,
          ($urandom % 16) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ras_ctrl.md
# ras_ctrl

Return-address-stack controller in fetch stage 1. It classifies each fetched JAL/JALR by the RISC-V link-register hint rules and drives push/pop on the 8-entry RAS. It returns the predicted return target to fetch, sequences two-cycle pop-then-push for coroutine jumps, and unwinds speculative pushes on a pipeline flush. It keeps speculative and committed depth counters so the RAS pointer can be realigned without exposing it.

## Interface
- `ras_depth`, default 8: RAS entry count; must equal the attached RAS `ras_size`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `fetch_valid` in 1: fetched instruction valid this cycle.
- `fetch_pc` in 64: PC of fetched instruction.
- `is_jal`, `is_jalr` in 1 each: predecoded jump type.
- `rd`, `rs1` in 5 each: instruction register fields.
- `stall` out 1: hold fetch; the instruction is re-presented unchanged next cycle.
- `pred_valid` out 1: `pred_target` is a valid return prediction.
- `pred_target` out 64: predicted return address.
- `commit_push`, `commit_pop` in 1 each: a retired instruction was classified push or pop (coroutine asserts both).
- `flush` in 1: pipeline flush from execute.
- `ras_push`, `ras_pop` out 1 each; `ras_idata` out 64: RAS command and data.
- `ras_odata` in 64; `ras_valid`, `ras_empty`, `ras_full` in 1 each: RAS response and status.

## Operation
- Link registers are x1 and x5.
- Hint decode:
  - JAL with rd=link: PUSH.
  - JALR with rd≠link, rs1=link: POP.
  - JALR with rd=link, rs1≠link: PUSH.
  - JALR with rd=link, rs1=link, rd≠rs1: POPPUSH.
  - JALR with rd=rs1=link: PUSH.
  - Anything else: NONE.
- FSM states:
  - IDLE: ops are taken only when `fetch_valid`.
    - PUSH: `ras_push=1`, `ras_idata=fetch_pc+4` (64-bit wrap).
    - POP: `ras_pop=1`; `pred_valid=ras_valid`, `pred_target=ras_odata`. An empty RAS gives `pred_valid=0`.
    - POPPUSH: pop as above, latch `fetch_pc+4`, assert `stall`, go to COPUSH.
  - COPUSH: `ras_push=1` with the latched data, `stall=0`, return to IDLE. `fetch_valid` is ignored.
  - RECOVER: `stall=1`. Pop once per cycle while `spec_depth>commit_depth`, then go to IDLE.
- `spec_depth` and `commit_depth` are `$clog2(ras_depth+1)` bits wide and saturate at 0 and `ras_depth`.
  - `spec_depth` follows issued push/pop.
  - `commit_depth` follows commit_push/commit_pop. When both are asserted, the depth is unchanged.
- Flush has priority in every state. It suppresses this cycle's fetch ops and enters RECOVER, or IDLE if `spec_depth<=commit_depth`.
  - If `spec_depth<commit_depth`, set `spec_depth:=commit_depth`. Entries lost to speculative pops are not restored.
- A flush during RECOVER re-evaluates against the current `commit_depth`.
- A flush during COPUSH drops the pending push.
- A push while full is issued but lost by the RAS; `spec_depth` stays at `ras_depth`.

## Timing
- Reset values:
  - State IDLE, both depths 0, latched data 0.
  - All outputs 0: `stall`, `pred_valid`, `pred_target`, `ras_push`, `ras_pop`, `ras_idata`.
- Prediction is combinational: `pred_*` are valid in the same cycle as the POP fetch.
- Pushed data is visible to a pop in the next cycle.
- A POPPUSH takes 2 cycles; `stall` is high in cycle 0 only.
- RECOVER takes (`spec_depth-commit_depth`) cycles of pops plus 0 extra; IDLE is reached on the edge after the last pop.
- `ras_push` and `ras_pop` are never asserted in the same cycle.

## Configuration
- `RAS_CTRL_COROUTINE_EN`:
  - Defined: POPPUSH is handled as above.
  - Undefined: POPPUSH is treated as PUSH in a single cycle with no prediction; COPUSH state is absent and `stall` is asserted only in RECOVER.

## Structure
- `ras_pkg` holds:
  - `ras_op_e` (NONE/PUSH/POP/POPPUSH).
  - `ras_state_e` (IDLE/COPUSH/RECOVER).
  - Constants `LINK_X1=5'd1`, `LINK_X5=5'd5`.
- Sub-module `ras_hint_decode` is purely combinational: inputs `is_jal`, `is_jalr`, `rd`, `rs1`; output `ras_op_e`.

## Test plan
- Call/return: JAL rd=x1 at PC 0x1000, then JALR rd=x0 rs1=x1 → push 0x1004; next cycle `pred_valid=1`, `pred_target=0x1004`.
- Coroutine: RAS holds 0x2004; JALR rd=x5 rs1=x1 at 0x3000 → cycle0 pred 0x2004 with `stall=1`; cycle1 push 0x3004 with `stall=0`; next pop predicts 0x3004.
- Overflow: 9 calls at PCs 0x100..0x900 → `spec_depth` saturates at 8; 8 returns predict 0x804 down to 0x104; the 9th return gives `pred_valid=0`.
- Recovery: `commit_depth=1`, 3 speculative pushes, then flush → `stall` high for 3 cycles with 3 pops; then a return predicts the committed entry.
- Flush mid-COPUSH and reset mid-RECOVER → no push is issued; after reset deassert all outputs are 0 and state is IDLE.
- Macro off: JALR rd=x1 rs1=x5 → single-cycle push, `stall=0`, `pred_valid=0`.
